// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I register-file write-back path.
package rv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/wb_rr_arb2.sv
// Two-way round-robin arbiter between the load unit and the mul/div unit.
module wb_rr_arb2
#(
    parameter bit LD_FIRST = 1'b1
)
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic req_ld_i,
    input  logic req_md_i,
    output logic gnt_ld_o,
    output logic gnt_md_o
);

    // rr_ptr_q = 1: load unit wins the next tie
    logic rr_ptr_q, rr_ptr_d;

    always_comb begin
        gnt_ld_o = en_i && req_ld_i && (rr_ptr_q || !req_md_i);
        gnt_md_o = en_i && req_md_i && (!rr_ptr_q || !req_ld_i);
        rr_ptr_d = rr_ptr_q;
        if (gnt_ld_o) begin
            rr_ptr_d = 1'b0;
        end else if (gnt_md_o) begin
            rr_ptr_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q <= LD_FIRST;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Regfile write-port sharing, busy scoreboard and decode read-hazard detection.
// Optional write-stage forwarding is enabled by defining WB_FORWARD_EN.
module regfile_wb_ctrl
    import rv_pkg::*;
#(
    parameter int XLEN     = rv_pkg::XLEN,
    parameter bit LD_FIRST = 1'b1
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    input  logic            md_valid,
    output logic            md_ready,
    input  logic [4:0]      md_rd,
    input  logic [XLEN-1:0] md_data,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic            issue_ready,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    output logic            hazard,
`ifdef WB_FORWARD_EN
    output logic            fwd1_sel,
    output logic            fwd2_sel,
    output logic [XLEN-1:0] fwd_data,
`endif
    output logic            we,
    output logic [4:0]      wa,
    output logic [XLEN-1:0] wd
);

    wb_req_t alu_req, ld_req, md_req, sel_req;
    logic    grant_ld, grant_md;

    logic            we_q, we_d;
    logic [4:0]      wa_q;
    logic [XLEN-1:0] wd_q;
    logic [31:0]     busy_q, busy_d;
    logic            issue_set;
    logic            src1_busy, src2_busy;

    assign alu_req = '{valid: alu_valid, rd: alu_rd, data: alu_data};
    assign ld_req  = '{valid: ld_valid,  rd: ld_rd,  data: ld_data};
    assign md_req  = '{valid: md_valid,  rd: md_rd,  data: md_data};

    // ld/md only compete when the ALU leaves the port free
    wb_rr_arb2 #(.LD_FIRST(LD_FIRST)) u_arb (
        .clk_i    (clk),
        .rst_i    (reset),
        .en_i     (!alu_valid),
        .req_ld_i (ld_valid),
        .req_md_i (md_valid),
        .gnt_ld_o (grant_ld),
        .gnt_md_o (grant_md)
    );

    assign ld_ready = grant_ld;
    assign md_ready = grant_md;

    always_comb begin
        sel_req = '0;
        if (alu_valid) begin
            sel_req = alu_req;
        end else if (grant_ld) begin
            sel_req = ld_req;
        end else if (grant_md) begin
            sel_req = md_req;
        end
    end

    assign we_d = sel_req.valid && (sel_req.rd != REG_ZERO);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q <= 1'b0;
            wa_q <= REG_ZERO;
            wd_q <= '0;
        end else begin
            we_q <= we_d;
            if (sel_req.valid) begin
                wa_q <= sel_req.rd;
                wd_q <= sel_req.data;
            end
        end
    end

    assign issue_ready = !busy_q[issue_rd] || (issue_rd == REG_ZERO);
    assign issue_set   = issue_valid && issue_ready && (issue_rd != REG_ZERO);

    // Clear on the regfile commit edge; a same-edge issue to that register wins
    always_comb begin
        busy_d = busy_q;
        if (we_q) begin
            busy_d[wa_q] = 1'b0;
        end
        if (issue_set) begin
            busy_d[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign src1_busy = (ra1 != REG_ZERO) && busy_q[ra1];
    assign src2_busy = (ra2 != REG_ZERO) && busy_q[ra2];

`ifdef WB_FORWARD_EN
    assign fwd1_sel = we_q && (wa_q == ra1) && (ra1 != REG_ZERO);
    assign fwd2_sel = we_q && (wa_q == ra2) && (ra2 != REG_ZERO);
    assign fwd_data = wd_q;
    assign hazard   = (src1_busy && !fwd1_sel) || (src2_busy && !fwd2_sel);
`else
    // Without forwarding, an in-flight ALU write also stalls its readers
    assign hazard = src1_busy || src2_busy
                 || (we_q && (wa_q == ra1) && (ra1 != REG_ZERO))
                 || (we_q && (wa_q == ra2) && (ra2 != REG_ZERO));
`endif

    assign we = we_q;
    assign wa = wa_q;
    assign wd = wd_q;

endmodule
